// File: rtl/tick_scheduler.sv
// Shared interval timer: grants one prescaled timebase to one of four requesters at a time.
// Define TICK_SCHED_RR_EN for round-robin arbitration; otherwise req[0] has fixed highest priority.
module tick_scheduler #(
  parameter int unsigned TICK_TARGET = 50000000,
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned DUR_W       = 8
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [3:0]         req,
  input  logic [4*DUR_W-1:0] dur,
  output logic [3:0]         gnt,
  output logic [3:0]         done,
  output logic               busy,
  output logic [DUR_W-1:0]   remaining,
  output logic               tick
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_TARGET - 1);
  localparam logic [CNT_W-1:0] TICK_PRE  = CNT_W'(TICK_TARGET - 2);
  localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);

  state_t             state;
  logic [CNT_W-1:0]   prescaler;
  logic [1:0]         owner;
  logic [1:0]         pick;
  logic [1:0]         idx;
  logic               found;
  logic [DUR_W-1:0]   dur_sel;

`ifdef TICK_SCHED_RR_EN
  logic [1:0]         last;
`endif

  always_comb begin
    found   = 1'b0;
    pick    = '0;
    idx     = '0;
    dur_sel = '0;
    for (int unsigned k = 0; k < 4; k++) begin
`ifdef TICK_SCHED_RR_EN
      idx = last + 2'(k + 1);
`else
      idx = 2'(k);
`endif
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    for (int unsigned k = 0; k < 4; k++) begin
      if (pick == 2'(k)) dur_sel = dur[k*DUR_W +: DUR_W];
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      remaining <= '0;
      tick      <= 1'b0;
      prescaler <= '0;
      owner     <= '0;
`ifdef TICK_SCHED_RR_EN
      last      <= 2'd3;
`endif
    end else begin
      done <= '0;
      tick <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state     <= RUN;
            gnt       <= 4'b0001 << pick;
            owner     <= pick;
            busy      <= 1'b1;
            remaining <= dur_sel;
            prescaler <= '0;
`ifdef TICK_SCHED_RR_EN
            last      <= pick;
`endif
          end
        end
        RUN: begin
          if (!req[owner]) begin
            state     <= IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            remaining <= '0;
            prescaler <= '0;
          end else if (remaining == '0) begin
            // Zero-delay grant: gnt is visible for one cycle, then completes without ticking.
            state     <= DONE;
            done      <= gnt;
            gnt       <= '0;
            prescaler <= '0;
          end else if (prescaler == TICK_LAST) begin
            prescaler <= '0;
            if (remaining == DUR_ONE) begin
              state     <= DONE;
              done      <= gnt;
              gnt       <= '0;
              remaining <= '0;
            end else begin
              remaining <= remaining - DUR_ONE;
            end
          end else begin
            prescaler <= prescaler + CNT_W'(1);
            // Registered tick lines up with the cycle where prescaler holds its last value.
            tick      <= (prescaler == TICK_PRE);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          busy      <= 1'b0;
          remaining <= '0;
          prescaler <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed self-checking bench for tick_scheduler (TICK_TARGET=4 instance plus a TICK_TARGET=2 instance).
module tb_tick_scheduler;

  logic        clk;
  logic        Reset;
  logic [3:0]  req_a, req_b;
  logic [31:0] dur_a, dur_b;
  logic [3:0]  gnt_a, gnt_b, done_a, done_b;
  logic        busy_a, busy_b, tick_a, tick_b;
  logic [7:0]  rem_a, rem_b;

  int tests = 0;
  int fails = 0;

  tick_scheduler #(.TICK_TARGET(4), .CNT_W(2), .DUR_W(8)) dut_a (
    .clk(clk), .Reset(Reset), .req(req_a), .dur(dur_a), .gnt(gnt_a),
    .done(done_a), .busy(busy_a), .remaining(rem_a), .tick(tick_a)
  );

  tick_scheduler #(.TICK_TARGET(2), .CNT_W(1), .DUR_W(8)) dut_b (
    .clk(clk), .Reset(Reset), .req(req_b), .dur(dur_b), .gnt(gnt_b),
    .done(done_b), .busy(busy_b), .remaining(rem_b), .tick(tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0] order [5];

  initial begin
`ifdef TICK_SCHED_RR_EN
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
`else
    order[0] = 4'b0001; order[1] = 4'b0001; order[2] = 4'b0001;
    order[3] = 4'b0001; order[4] = 4'b0001;
`endif
    Reset = 1'b1; req_a = '0; req_b = '0; dur_a = '0; dur_b = '0;
    cyc(2);
    chk("rst_gnt", 32'(gnt_a), 32'h0);
    chk("rst_done", 32'(done_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_rem", 32'(rem_a), 32'h0);
    chk("rst_tick", 32'(tick_a), 32'h0);
    chk("rst_gnt_b", 32'(gnt_b), 32'h0);
    Reset = 1'b0;

    // single request, dur=3
    req_a = 4'b0001; dur_a[7:0] = 8'd3;
    cyc(1);
    chk("s_gnt", 32'(gnt_a), 32'h1);
    chk("s_busy", 32'(busy_a), 32'h1);
    chk("s_rem", 32'(rem_a), 32'd3);
    chk("s_tick0", 32'(tick_a), 32'h0);
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      if (k < 12) begin
        chk("s_run_gnt", 32'(gnt_a), 32'h1);
        chk("s_run_rem", 32'(rem_a), 32'(3 - k / 4));
        chk("s_run_tick", 32'(tick_a), 32'((k % 4) == 3));
        chk("s_run_done", 32'(done_a), 32'h0);
      end else begin
        chk("s_done", 32'(done_a), 32'h1);
        chk("s_done_gnt", 32'(gnt_a), 32'h0);
        chk("s_done_rem", 32'(rem_a), 32'h0);
        chk("s_done_tick", 32'(tick_a), 32'h0);
        chk("s_done_busy", 32'(busy_a), 32'h1);
      end
    end
    req_a = '0;
    cyc(1);
    chk("s_idle_done", 32'(done_a), 32'h0);
    chk("s_idle_busy", 32'(busy_a), 32'h0);

    // zero delay on requester 2
    req_a = 4'b0100; dur_a[23:16] = 8'd0;
    cyc(1);
    chk("z_gnt", 32'(gnt_a), 32'h4);
    chk("z_rem", 32'(rem_a), 32'h0);
    chk("z_tick0", 32'(tick_a), 32'h0);
    chk("z_done0", 32'(done_a), 32'h0);
    cyc(1);
    chk("z_done", 32'(done_a), 32'h4);
    chk("z_gnt_off", 32'(gnt_a), 32'h0);
    chk("z_tick1", 32'(tick_a), 32'h0);
    req_a = '0;
    cyc(1);
    chk("z_idle", 32'(busy_a), 32'h0);

    // contention after a fresh reset, all dur=1
    Reset = 1'b1;
    cyc(1);
    Reset = 1'b0;
    dur_a = 32'h01010101; req_a = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("c_gnt", 32'(gnt_a), 32'(order[i]));
      cyc(4);
      chk("c_done", 32'(done_a), 32'(order[i]));
      chk("c_done_gnt", 32'(gnt_a), 32'h0);
      cyc(1);
      chk("c_idle_gnt", 32'(gnt_a), 32'h0);
      chk("c_idle_busy", 32'(busy_a), 32'h0);
    end
    req_a = '0;
    cyc(1);

    // abort with req[3] pending
    dur_a[15:8] = 8'd5; dur_a[31:24] = 8'd2; req_a = 4'b1010;
    cyc(1);
    chk("a_gnt", 32'(gnt_a), 32'h2);
    chk("a_rem", 32'(rem_a), 32'd5);
    cyc(5);
    chk("a_gnt_held", 32'(gnt_a), 32'h2);
    chk("a_rem_held", 32'(rem_a), 32'd4);
    req_a = 4'b1000;
    cyc(1);
    chk("a_gnt_off", 32'(gnt_a), 32'h0);
    chk("a_rem_off", 32'(rem_a), 32'h0);
    chk("a_no_done", 32'(done_a), 32'h0);
    chk("a_busy_off", 32'(busy_a), 32'h0);
    cyc(1);
    chk("a_gnt3", 32'(gnt_a), 32'h8);
    chk("a_rem3", 32'(rem_a), 32'd2);

    // asynchronous reset mid-RUN
    #2 Reset = 1'b1;
    #1;
    chk("r_gnt", 32'(gnt_a), 32'h0);
    chk("r_busy", 32'(busy_a), 32'h0);
    chk("r_rem", 32'(rem_a), 32'h0);
    chk("r_done", 32'(done_a), 32'h0);
    @(negedge clk);
    chk("r_held_done", 32'(done_a), 32'h0);
    Reset = 1'b0; req_a = 4'b0001; dur_a[7:0] = 8'd3;
    cyc(1);
    chk("r_new_gnt", 32'(gnt_a), 32'h1);
    chk("r_new_rem", 32'(rem_a), 32'd3);
    cyc(2);
    chk("r_tick_early", 32'(tick_a), 32'h0);
    cyc(1);
    chk("r_tick", 32'(tick_a), 32'h1);
    req_a = '0;
    cyc(1);
    chk("r_abort_gnt", 32'(gnt_a), 32'h0);
    chk("r_abort_done", 32'(done_a), 32'h0);

    // max delay on the TICK_TARGET=2 instance
    req_b = 4'b0001; dur_b[7:0] = 8'd255;
    cyc(1);
    chk("m_gnt", 32'(gnt_b), 32'h1);
    chk("m_rem", 32'(rem_b), 32'd255);
    for (int k = 1; k <= 510; k++) begin
      cyc(1);
      if (k < 510) begin
        chk("m_run_rem", 32'(rem_b), 32'(255 - k / 2));
        chk("m_run_done", 32'(done_b), 32'h0);
      end else begin
        chk("m_done", 32'(done_b), 32'h1);
        chk("m_done_gnt", 32'(gnt_b), 32'h0);
        chk("m_done_rem", 32'(rem_b), 32'h0);
      end
    end
    req_b = '0;
    cyc(1);
    chk("m_idle_rem", 32'(rem_b), 32'h0);
    chk("m_idle_busy", 32'(busy_b), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
